return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- Parametrised hardware return-address stack (LIFO) for the CALL/RET path of the simple processor.
- Successor to the fixed 8-bit stack: width, depth, return-offset and overflow policy are configurable.
- Adds count, full/empty and sticky overflow/underflow error flags, with defined simultaneous push/pop behaviour.
- The PC feeds push_data; top drives the stack input of the PC-load mux.

Parameters:
- WIDTH, 8: bits per entry (PC width).
- DEPTH, 8: number of entries; must be ≥2.
- RET_OFFSET, 0: constant added to push_data before storing, mod 2^WIDTH (1 stores PC+1).
- OVF_MODE, 0: 0 = reject a push when full; 1 = circular, a push when full overwrites the oldest entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low (asserted at 0).
- push  in  1  push request (CALL).
- pop  in  1  pop request (RET).
- push_data  in  WIDTH  value to push (current PC).
- clr_err  in  1  synchronous clear of the sticky error flags.
- top  out  WIDTH  current top entry; 0 when empty.
- count  out  CW = clog2(DEPTH+1)  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag: a push hit full.
- underflow  out  1  sticky flag: a pop hit empty.

Behaviour:
- Reset (reset=0, asynchronous): count=0, write pointer=0, overflow=0, underflow=0. Storage is not cleared. Outputs: top=0, empty=1, full=0.
- All updates occur on the rising edge of clk. top, count, empty and full are combinational from state, so they reflect the result in the same cycle as the edge (zero-cycle read latency). A pop in cycle n returns top from before edge n; the PC loads that value at the same edge.
- Stored value = (push_data + RET_OFFSET) mod 2^WIDTH, truncated to WIDTH.
- Push only, not full: write mem[wp], wp = (wp+1) mod DEPTH, count+1.
- Push only, full:
  - OVF_MODE=0: push ignored, state unchanged, overflow=1.
  - OVF_MODE=1: write mem[wp], wp advances, count stays DEPTH, overflow=1. The oldest entry is lost.
- Pop only, not empty: wp = (wp−1) mod DEPTH, count−1.
- Pop only, empty: no change, underflow=1.
- Push and pop, count ≥ 1: replace the top entry, mem[(wp−1) mod DEPTH] = stored value. count and wp are unchanged, even when full. No flags set.
- Push and pop, empty: the pop is ignored and underflow=1. The push executes, so count=1 and top = stored value.
- Neither push nor pop: hold.
- clr_err clears both flags at the edge. If a new error event occurs in the same cycle, the flag is set (set has priority over clear).
- top = mem[(wp−1) mod DEPTH] when count > 0, else 0.
- Pointer arithmetic wraps explicitly modulo DEPTH, including non-power-of-2 DEPTH.
- An asynchronous reset mid-sequence takes effect immediately. The first edge after release behaves as on an empty stack.

Decomposition:
- Shared package:
  - OVF_REJECT=0 and OVF_WRAP=1 constants.
  - Count-width helper function (clog2(DEPTH+1)).
- One sub-module: lifo_storage, holding the WIDTH×DEPTH register array with one write port and one asynchronous read port, no reset.
- return_stack keeps the pointer, count, flag and control logic.

Test Plan:
- Reset, then push 0x10, 0x20, 0x30 (RET_OFFSET=1) → top=0x31, count=3; three pops → top 0x21, 0x11, then 0, empty=1.
- Pop when empty → underflow=1, count=0. clr_err=1 next cycle → underflow=0. Pop together with clr_err → underflow stays 1.
- DEPTH=4, OVF_MODE=0: push 1,2,3,4,5 → full=1, overflow=1, top=4. Four pops yield 4,3,2,1.
- DEPTH=4, OVF_MODE=1: push 1..6 → count=4, overflow=1. Pops yield 6,5,4,3, then empty=1.
- Push+pop with count=2 (top 0x22), push_data=0x40, RET_OFFSET=0 → top=0x40, count=2. Push+pop when empty → count=1, top=push_data, underflow=1.
- Assert reset low between edges during a push burst → count=0, empty=1, flags=0 immediately. After release, a push of 0xFF with RET_OFFSET=1 → top=0x00 (wrap mod 2^8).

Source files
------------

// File: rtl/return_stack_pkg.sv
// Shared constants and helpers for the return-address stack.
// The overflow-policy encodings and the count-width rule live here so both RTL and users agree on them.
package return_stack_pkg;

    localparam int OVF_REJECT = 0;
    localparam int OVF_WRAP   = 1;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/return_stack_lifo_storage.sv
// Register array behind the return stack: one synchronous write port, one asynchronous read port.
// Contents are undefined until written; validity is tracked by the stack's count.
module lifo_storage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset on purpose; an empty stack never exposes it, and leaving it out keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Parametrised return-address stack for the CALL/RET path: pointer, count, sticky error flags and control.
// top/count/empty/full are combinational from state, so a RET sees the return address without a cycle of delay.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int RET_OFFSET = 0,
    parameter int OVF_MODE   = OVF_REJECT,
    parameter int CW         = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [AW-1:0]    wp_next, wp_prev, waddr;
    logic [WIDTH-1:0] store_val, rdata;
    logic             is_empty, is_full, we, ovf_evt, unf_evt;

    // Explicit wrap so non-power-of-2 depths never index past the array.
    assign wp_next   = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    assign wp_prev   = (wp_q == '0) ? AW'(DEPTH - 1) : wp_q - 1'b1;
    assign store_val = push_data + WIDTH'(RET_OFFSET);
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CW'(DEPTH));

    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = wp_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    we      = 1'b1;
                    wp_d    = wp_next;
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_evt = 1'b1;
                    if (OVF_MODE == OVF_WRAP) begin
                        we   = 1'b1;
                        wp_d = wp_next;
                    end
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    wp_d    = wp_prev;
                    count_d = count_q - 1'b1;
                end else begin
                    unf_evt = 1'b1;
                end
            end
            2'b11: begin
                // Simultaneous CALL/RET replaces the top in place; on an empty stack only the push survives.
                if (!is_empty) begin
                    we    = 1'b1;
                    waddr = wp_prev;
                end else begin
                    unf_evt = 1'b1;
                    we      = 1'b1;
                    wp_d    = wp_next;
                    count_d = CW'(1);
                end
            end
            default: ;
        endcase
        overflow_d  = ovf_evt | (overflow_q & ~clr_err);
        underflow_d = unf_evt | (underflow_q & ~clr_err);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    lifo_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (store_val),
        .raddr (wp_prev),
        .rdata (rdata)
    );

    assign top       = is_empty ? '0 : rdata;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack across four configurations sharing one clock and reset.
// Expected values are hand-derived from the stack's documented behaviour.
module tb_return_stack;
    import return_stack_pkg::*;

    logic clk;
    logic reset;
    logic       push_v [4];
    logic       pop_v  [4];
    logic       clr_v  [4];
    logic [7:0] din_v  [4];
    logic [7:0] top_v  [4];
    logic       empty_v [4];
    logic       full_v  [4];
    logic       ovf_v   [4];
    logic       unf_v   [4];
    logic [3:0] cnt0;
    logic [2:0] cnt1, cnt2, cnt3;

    int checks = 0;
    int errors = 0;

    // u0: DEPTH 8, offset 1, reject
    return_stack #(.WIDTH(8), .DEPTH(8), .RET_OFFSET(1), .OVF_MODE(OVF_REJECT)) u0 (
        .clk(clk), .reset(reset), .push(push_v[0]), .pop(pop_v[0]), .push_data(din_v[0]),
        .clr_err(clr_v[0]), .top(top_v[0]), .count(cnt0), .empty(empty_v[0]), .full(full_v[0]),
        .overflow(ovf_v[0]), .underflow(unf_v[0]));

    // u1: DEPTH 4, reject
    return_stack #(.WIDTH(8), .DEPTH(4), .RET_OFFSET(0), .OVF_MODE(OVF_REJECT)) u1 (
        .clk(clk), .reset(reset), .push(push_v[1]), .pop(pop_v[1]), .push_data(din_v[1]),
        .clr_err(clr_v[1]), .top(top_v[1]), .count(cnt1), .empty(empty_v[1]), .full(full_v[1]),
        .overflow(ovf_v[1]), .underflow(unf_v[1]));

    // u2: DEPTH 4, circular
    return_stack #(.WIDTH(8), .DEPTH(4), .RET_OFFSET(0), .OVF_MODE(OVF_WRAP)) u2 (
        .clk(clk), .reset(reset), .push(push_v[2]), .pop(pop_v[2]), .push_data(din_v[2]),
        .clr_err(clr_v[2]), .top(top_v[2]), .count(cnt2), .empty(empty_v[2]), .full(full_v[2]),
        .overflow(ovf_v[2]), .underflow(unf_v[2]));

    // u3: DEPTH 5 (non-power-of-2), circular
    return_stack #(.WIDTH(8), .DEPTH(5), .RET_OFFSET(0), .OVF_MODE(OVF_WRAP)) u3 (
        .clk(clk), .reset(reset), .push(push_v[3]), .pop(pop_v[3]), .push_data(din_v[3]),
        .clr_err(clr_v[3]), .top(top_v[3]), .count(cnt3), .empty(empty_v[3]), .full(full_v[3]),
        .overflow(ovf_v[3]), .underflow(unf_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clocked operation on instance i; inputs return to idle 1ns after the edge.
    task automatic op(input int i, input logic pu, input logic po, input logic [7:0] d, input logic ce);
        push_v[i] = pu;
        pop_v[i]  = po;
        din_v[i]  = d;
        clr_v[i]  = ce;
        @(posedge clk);
        #1;
        push_v[i] = 1'b0;
        pop_v[i]  = 1'b0;
        clr_v[i]  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            push_v[i] = 1'b0;
            pop_v[i]  = 1'b0;
            clr_v[i]  = 1'b0;
            din_v[i]  = 8'h00;
        end
        reset = 1'b0;
        #12;
        check("rst_top",   top_v[0], 8'h00);
        check("rst_count", cnt0, 4'd0);
        check("rst_empty", empty_v[0], 1'b1);
        check("rst_full",  full_v[0], 1'b0);
        check("rst_flags", {ovf_v[0], unf_v[0]}, 2'b00);
        reset = 1'b1;

        // Basic LIFO with RET_OFFSET=1
        op(0, 1, 0, 8'h10, 0);
        op(0, 1, 0, 8'h20, 0);
        op(0, 1, 0, 8'h30, 0);
        check("push3_top",   top_v[0], 8'h31);
        check("push3_count", cnt0, 4'd3);
        op(0, 0, 1, 8'h00, 0);
        check("pop1_top", top_v[0], 8'h21);
        op(0, 0, 1, 8'h00, 0);
        check("pop2_top", top_v[0], 8'h11);
        op(0, 0, 1, 8'h00, 0);
        check("pop3_top",   top_v[0], 8'h00);
        check("pop3_empty", empty_v[0], 1'b1);

        // Underflow and clear priority
        op(0, 0, 1, 8'h00, 0);
        check("unf_set",   unf_v[0], 1'b1);
        check("unf_count", cnt0, 4'd0);
        op(0, 0, 0, 8'h00, 1);
        check("unf_clr", unf_v[0], 1'b0);
        op(0, 0, 1, 8'h00, 1);
        check("unf_set_over_clr", unf_v[0], 1'b1);

        // DEPTH 4, reject policy
        for (int k = 1; k <= 4; k++) op(1, 1, 0, 8'(k), 0);
        check("rej_full4",  full_v[1], 1'b1);
        check("rej_ovf0",   ovf_v[1], 1'b0);
        op(1, 1, 0, 8'h05, 0);
        check("rej_full",  full_v[1], 1'b1);
        check("rej_ovf",   ovf_v[1], 1'b1);
        check("rej_top",   top_v[1], 8'h04);
        check("rej_count", cnt1, 3'd4);
        op(1, 0, 1, 8'h00, 0);
        check("rej_pop_a", top_v[1], 8'h03);
        op(1, 0, 1, 8'h00, 0);
        check("rej_pop_b", top_v[1], 8'h02);
        op(1, 0, 1, 8'h00, 0);
        check("rej_pop_c", top_v[1], 8'h01);
        op(1, 0, 1, 8'h00, 0);
        check("rej_pop_d", empty_v[1], 1'b1);

        // DEPTH 4, circular policy
        for (int k = 1; k <= 6; k++) op(2, 1, 0, 8'(k), 0);
        check("wrap_count", cnt2, 3'd4);
        check("wrap_ovf",   ovf_v[2], 1'b1);
        check("wrap_top",   top_v[2], 8'h06);
        op(2, 0, 1, 8'h00, 0);
        check("wrap_pop_a", top_v[2], 8'h05);
        op(2, 0, 1, 8'h00, 0);
        check("wrap_pop_b", top_v[2], 8'h04);
        op(2, 0, 1, 8'h00, 0);
        check("wrap_pop_c", top_v[2], 8'h03);
        op(2, 0, 1, 8'h00, 0);
        check("wrap_empty", empty_v[2], 1'b1);
        check("wrap_top0",  top_v[2], 8'h00);

        // Simultaneous push/pop on DEPTH 5
        op(3, 1, 0, 8'h11, 0);
        op(3, 1, 0, 8'h22, 0);
        check("pp_pre_top", top_v[3], 8'h22);
        op(3, 1, 1, 8'h40, 0);
        check("pp_top",   top_v[3], 8'h40);
        check("pp_count", cnt3, 3'd2);
        check("pp_flags", {ovf_v[3], unf_v[3]}, 2'b00);
        op(3, 0, 1, 8'h00, 0);
        check("pp_under", top_v[3], 8'h11);
        op(3, 0, 1, 8'h00, 0);
        op(3, 1, 1, 8'h55, 0);
        check("ppe_count", cnt3, 3'd1);
        check("ppe_top",   top_v[3], 8'h55);
        check("ppe_unf",   unf_v[3], 1'b1);

        // Non-power-of-2 pointer wrap: wp starts at 1, wraps 4->0 then overwrites oldest
        op(3, 0, 0, 8'h00, 1);
        for (int k = 1; k <= 4; k++) op(3, 1, 0, 8'(k), 0);
        check("d5_full", full_v[3], 1'b1);
        check("d5_top4", top_v[3], 8'h04);
        op(3, 1, 0, 8'h05, 0);
        check("d5_ovf_top",   top_v[3], 8'h05);
        check("d5_ovf_count", cnt3, 3'd5);
        check("d5_ovf",       ovf_v[3], 1'b1);
        op(3, 0, 1, 8'h00, 0);
        check("d5_pop_wrap", top_v[3], 8'h04);

        // Asynchronous reset in the middle of a push burst
        op(0, 1, 0, 8'hAA, 0);
        op(0, 1, 0, 8'hBB, 0);
        check("burst_top", top_v[0], 8'hBC);
        push_v[0] = 1'b1;
        din_v[0]  = 8'hCC;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", cnt0, 4'd0);
        check("arst_empty", empty_v[0], 1'b1);
        check("arst_top",   top_v[0], 8'h00);
        check("arst_flags", {ovf_v[0], unf_v[0]}, 2'b00);
        push_v[0] = 1'b0;
        #1;
        reset = 1'b1;
        op(0, 1, 0, 8'hFF, 0);
        check("post_top",   top_v[0], 8'h00);
        check("post_count", cnt0, 4'd1);
        check("post_empty", empty_v[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
